// File: rtl/snell_solver.sv
// Snell's-law index solver: n1 = floor(n2 * sin(theta2) / sin(theta1)).
// Sine table lookup, one multiply, then a bit-serial restoring divide.
module snell_solver #(
    parameter int unsigned N_W    = 4,
    parameter int unsigned FRAC_N = 2,
    parameter int unsigned ANG_W  = 7,
    parameter int unsigned OUT_W  = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_W-1:0]   n2,
    input  logic [ANG_W-1:0] theta1,
    input  logic [ANG_W-1:0] theta2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] n1,
    output logic             div_zero,
    output logic             sat
);
    localparam int unsigned S_W    = 9;
    localparam int unsigned QW     = N_W + S_W;
    localparam int unsigned R_W    = S_W + 1;
    localparam int unsigned CNT_W  = $clog2(QW);
    localparam int unsigned N1_MAX = (2 ** OUT_W) - 1;

    // Both indices share the binary point, so FRAC_N only has to fit inside N_W.
    if (FRAC_N > N_W) begin : g_bad_frac
        $error("FRAC_N exceeds N_W");
    end

    // round(sin(a deg) * 256), a = 0..90
    localparam logic [S_W-1:0] SIN_TBL [91] = '{
        9'd0,   9'd4,   9'd9,   9'd13,  9'd18,  9'd22,  9'd27,  9'd31,  9'd36,  9'd40,
        9'd44,  9'd49,  9'd53,  9'd58,  9'd62,  9'd66,  9'd71,  9'd75,  9'd79,  9'd83,
        9'd88,  9'd92,  9'd96,  9'd100, 9'd104, 9'd108, 9'd112, 9'd116, 9'd120, 9'd124,
        9'd128, 9'd132, 9'd136, 9'd139, 9'd143, 9'd147, 9'd150, 9'd154, 9'd158, 9'd161,
        9'd165, 9'd168, 9'd171, 9'd175, 9'd178, 9'd181, 9'd184, 9'd187, 9'd190, 9'd193,
        9'd196, 9'd199, 9'd202, 9'd204, 9'd207, 9'd210, 9'd212, 9'd215, 9'd217, 9'd219,
        9'd222, 9'd224, 9'd226, 9'd228, 9'd230, 9'd232, 9'd234, 9'd236, 9'd237, 9'd239,
        9'd241, 9'd242, 9'd243, 9'd245, 9'd246, 9'd247, 9'd248, 9'd249, 9'd250, 9'd251,
        9'd252, 9'd253, 9'd254, 9'd254, 9'd255, 9'd255, 9'd255, 9'd256, 9'd256, 9'd256,
        9'd256
    };

    typedef enum logic [2:0] {IDLE, LOOKUP, MUL, DIV, DONE} state_t;

    state_t           state;
    logic [N_W-1:0]   n2_q;
    logic [ANG_W-1:0] t1_q;
    logic [ANG_W-1:0] t2_q;
    logic [S_W-1:0]   s1;
    logic [S_W-1:0]   s2;
    logic [QW-1:0]    prod;
    logic [QW-1:0]    quo;
    logic [R_W-1:0]   rem;
    logic [CNT_W-1:0] cnt;
    logic             dz_q;
    logic [R_W-1:0]   rem_sh;
    logic             fits;
    logic [R_W-1:0]   rem_nx;

    function automatic logic [6:0] ang_idx(input logic [ANG_W-1:0] a);
        return (a > ANG_W'(90)) ? 7'd90 : 7'(a);
    endfunction

    // One restoring-divide step: bring down the next dividend bit, subtract if it fits.
    always_comb begin
        rem_sh = {rem[S_W-1:0], prod[QW-1]};
        fits   = (rem_sh >= R_W'(s1));
        rem_nx = fits ? (rem_sh - R_W'(s1)) : rem_sh;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            n1        <= '0;
            div_zero  <= 1'b0;
            sat       <= 1'b0;
            n2_q      <= '0;
            t1_q      <= '0;
            t2_q      <= '0;
            s1        <= '0;
            s2        <= '0;
            prod      <= '0;
            quo       <= '0;
            rem       <= '0;
            cnt       <= '0;
            dz_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        n2_q     <= n2;
                        t1_q     <= theta1;
                        t2_q     <= theta2;
                        in_ready <= 1'b0;
                        state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    s1    <= SIN_TBL[ang_idx(t1_q)];
                    s2    <= SIN_TBL[ang_idx(t2_q)];
                    state <= MUL;
                end
                MUL: begin
                    prod  <= QW'(n2_q) * QW'(s2);
                    quo   <= '0;
                    rem   <= '0;
                    cnt   <= '0;
                    dz_q  <= (s1 == '0);
                    state <= (s1 == '0) ? DONE : DIV;
                end
                DIV: begin
                    rem  <= rem_nx;
                    prod <= prod << 1;
                    quo  <= {quo[QW-2:0], fits};
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(QW - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle clips and publishes; later cycles wait for the consumer.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        if (dz_q) begin
                            n1       <= '1;
                            div_zero <= 1'b1;
                            sat      <= 1'b1;
                        end else if (quo > QW'(N1_MAX)) begin
                            n1       <= '1;
                            div_zero <= 1'b0;
                            sat      <= 1'b1;
                        end else begin
                            n1       <= OUT_W'(quo);
                            div_zero <= 1'b0;
                            sat      <= 1'b0;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_snell_solver.sv
// Self-checking bench for snell_solver: directed corner cases plus random requests
// against a real-arithmetic Snell's-law model.
module tb_snell_solver;
    localparam int N1_MAX  = 127;
    localparam int LAT_DIV = 16;
    localparam int LAT_DZ  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] n2;
    logic [6:0] theta1;
    logic [6:0] theta2;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] n1;
    logic       div_zero;
    logic       sat;

    int checks   = 0;
    int failures = 0;

    snell_solver dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .n2        (n2),
        .theta1    (theta1),
        .theta2    (theta2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .n1        (n1),
        .div_zero  (div_zero),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int s_ref(input int a);
        int  aa;
        real r;
        aa = (a > 90) ? 90 : a;
        r  = $sin(real'(aa) * 3.14159265358979 / 180.0) * 256.0;
        return $rtoi(r + 0.5);
    endfunction

    task automatic model(input int a_n2, input int a_t1, input int a_t2,
                         output int e_n1, output int e_dz, output int e_sat, output int e_lat);
        int q;
        if (s_ref(a_t1) == 0) begin
            e_n1 = N1_MAX; e_dz = 1; e_sat = 1; e_lat = LAT_DZ;
        end else begin
            q     = (a_n2 * s_ref(a_t2)) / s_ref(a_t1);
            e_sat = (q > N1_MAX) ? 1 : 0;
            e_n1  = e_sat ? N1_MAX : q;
            e_dz  = 0;
            e_lat = LAT_DIV;
        end
    endtask

    // Called #1 after the accept edge; waits for out_valid and checks the result.
    task automatic wait_result(input int e_n1, input int e_dz, input int e_sat, input int e_lat);
        int cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", cyc, e_lat);
        check("n1", 32'(n1), e_n1);
        check("div_zero", 32'(div_zero), e_dz);
        check("sat", 32'(sat), e_sat);
    endtask

    task automatic run_req(input int a_n2, input int a_t1, input int a_t2, input int stall);
        int e_n1, e_dz, e_sat, e_lat;
        model(a_n2, a_t1, a_t2, e_n1, e_dz, e_sat, e_lat);
        check("in_ready_idle", 32'(in_ready), 1);
        in_valid = 1'b1;
        n2       = 4'(a_n2);
        theta1   = 7'(a_t1);
        theta2   = 7'(a_t2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n2       = 4'($urandom);
        theta1   = 7'($urandom);
        theta2   = 7'($urandom);
        check("in_ready_busy", 32'(in_ready), 0);
        wait_result(e_n1, e_dz, e_sat, e_lat);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_valid", 32'(out_valid), 1);
            check("stall_n1", 32'(n1), e_n1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("valid_drop", 32'(out_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int e_n1, e_dz, e_sat, e_lat, seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n2        = '0;
        theta1    = '0;
        theta2    = '0;
        #12;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_n1", 32'(n1), 0);
        check("rst_dz", 32'(div_zero), 0);
        check("rst_sat", 32'(sat), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_req(6, 90, 30, 0);
        run_req(4, 30, 90, 1);
        run_req(15, 1, 90, 2);
        run_req(9, 0, 45, 0);
        run_req(0, 20, 70, 0);
        run_req(0, 0, 70, 0);
        run_req(4, 120, 100, 0);

        // Long stall with next request already waiting on in_valid.
        model(6, 90, 30, e_n1, e_dz, e_sat, e_lat);
        in_valid = 1'b1; n2 = 4'd6; theta1 = 7'd90; theta2 = 7'd30;
        @(posedge clk); #1;
        n2 = 4'd4; theta1 = 7'd30; theta2 = 7'd90;
        wait_result(e_n1, e_dz, e_sat, e_lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 1);
            check("hold_n1", 32'(n1), e_n1);
            check("hold_sat", 32'(sat), e_sat);
            check("hold_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hs_valid_drop", 32'(out_valid), 0);
        check("hs_no_accept", 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("late_accept", 32'(in_ready), 0);
        model(4, 30, 90, e_n1, e_dz, e_sat, e_lat);
        wait_result(e_n1, e_dz, e_sat, e_lat);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset during DIV discards the request.
        in_valid = 1'b1; n2 = 4'd15; theta1 = 7'd1; theta2 = 7'd90;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 1);
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_n1", 32'(n1), 0);
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("midrst_no_valid", seen, 0);
        run_req(4, 45, 45, 0);

        for (int k = 0; k < 40; k++) begin
            int rn2, rt1, rt2;
            rn2 = int'($urandom_range(0, 15));
            rt1 = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 127));
            rt2 = int'($urandom_range(0, 127));
            run_req(rn2, rt1, rt2, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
